// File: rtl/vec_alu_engine.sv
// vec_alu_engine: walks N RAM elements through the shared ALU in element-wise or reduction mode
module vec_alu_engine #(
  parameter int DW  = 32,
  parameter int AW  = 8,
  parameter int LW  = AW + 1,
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic [OPW-1:0] op,
  input  logic [AW-1:0]  base_a,
  input  logic [AW-1:0]  base_b,
  input  logic [AW-1:0]  base_d,
  input  logic [LW-1:0]  len,
  input  logic [DW-1:0]  init_val,
  output logic           busy,
  output logic           done,
  output logic [DW-1:0]  result,
  output logic           wea,
  output logic [AW-1:0]  addra,
  output logic [DW-1:0]  dina,
  output logic [AW-1:0]  addrb,
  input  logic [DW-1:0]  doutb,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_out
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXE, ACC, WR, DONE} state_t;
  state_t state, nxt;
  logic           mode_q;
  logic [OPW-1:0] op_q;
  logic [AW-1:0]  ba_q, bb_q, bd_q, addra_q, addrb_q;
  logic [LW-1:0]  len_q, i;
  logic [DW-1:0]  acc, opa, opb, dina_q, alu_a_q, alu_b_q, result_q;
  logic [AW-1:0]  ia;
  logic           last;
  assign ia   = i[AW-1:0];
  assign last = (i + LW'(1)) == len_q;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ((len == '0) ? DONE : RD_A) : IDLE;
      RD_A:    nxt = mode_q ? EXE : RD_B;
      RD_B:    nxt = EXE;
      EXE:     nxt = mode_q ? ACC : WR;
      ACC:     nxt = last ? WR : RD_A;
      WR:      nxt = (mode_q || last) ? DONE : RD_A;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Outside their active state the port signals hold their last driven value
  assign busy   = state != IDLE;
  assign done   = state == DONE;
  assign wea    = state == WR;
  assign addra  = wea ? (mode_q ? bd_q : bd_q + ia) : addra_q;
  assign dina   = wea ? (mode_q ? acc : alu_out) : dina_q;
  assign addrb  = (state == RD_A) ? ba_q + ia : (state == RD_B) ? bb_q + ia : addrb_q;
  assign alu_a  = (wea && !mode_q) ? opa : (state == ACC) ? acc : alu_a_q;
  assign alu_b  = ((wea && !mode_q) || state == ACC) ? opb : alu_b_q;
  assign alu_op = op_q;
  assign result = result_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      op_q     <= '0;
      ba_q     <= '0;
      bb_q     <= '0;
      bd_q     <= '0;
      len_q    <= '0;
      i        <= '0;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      addra_q  <= '0;
      addrb_q  <= '0;
      dina_q   <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      result_q <= '0;
    end else begin
      state   <= nxt;
      addra_q <= addra;
      addrb_q <= addrb;
      dina_q  <= dina;
      alu_a_q <= alu_a;
      alu_b_q <= alu_b;
      if (state == IDLE && start) begin
        mode_q <= mode;
        op_q   <= op;
        ba_q   <= base_a;
        bb_q   <= base_b;
        bd_q   <= base_d;
        len_q  <= len;
        i      <= '0;
        acc    <= init_val;
      end
      if (state == RD_B) opa <= doutb;
      if (state == EXE) opb <= doutb;
      if (state == ACC) begin
        acc <= alu_out;
        i   <= i + LW'(1);
      end
      if (wea) begin
        result_q <= dina;
        if (!mode_q) i <= i + LW'(1);
      end
    end
  end
endmodule

// File: doc/vec_alu_engine.md
# vec_alu_engine

Parametrised vector sequencer generalising the single-operation state-machine datapath: on a start pulse it walks N elements in the on-chip dual-port RAM, pushes operands through the shared ALU and writes results back. It supports element-wise mode (D[i] = A[i] op B[i]) and reduction mode (acc = acc op A[i], final acc stored to D[0]). It sits beside the ALU and RAM in the top level and owns the RAM write port and read port while busy.

## Interface

- DW, 32: data width (RAM word, ALU operands)
- AW, 8: RAM address width
- LW, AW+1: length width (N up to 2^AW)
- OPW, 5: ALU opcode width

- clk  input  1  sole clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = element-wise, 1 = reduction; latched at start
- op  input  OPW  ALU opcode; latched at start
- base_a, base_b, base_d  input  AW  operand/destination base addresses; latched at start
- len  input  LW  element count N; latched at start
- init_val  input  DW  reduction accumulator seed; latched at start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse in DONE
- result  output  DW  last value written; held until next accepted start
- wea  output  1  RAM write enable (port A)
- addra  output  AW  RAM write address
- dina  output  DW  RAM write data
- addrb  output  AW  RAM read address (port B)
- doutb  input  DW  RAM read data, valid one cycle after addrb
- alu_a, alu_b  output  DW  ALU operands
- alu_op  output  OPW  ALU opcode (= latched op)
- alu_out  input  DW  combinational ALU result

## Operation

- States: IDLE, RD_A, RD_B, EXE, ACC, WR, DONE.
- IDLE: start=1 latches all inputs, clears index i; len=0 -> DONE; else -> RD_A. start in any other state ignored.
- Element-wise: RD_A (addrb=base_a+i) -> RD_B (addrb=base_b+i, opa<=doutb) -> EXE (opb<=doutb) -> WR (alu_a=opa, alu_b=opb, wea=1, addra=base_d+i, dina=alu_out, result<=alu_out, i++) -> RD_A, or DONE if i was N-1.
- Reduction: acc<=init_val at start. RD_A (addrb=base_a+i) -> EXE (opb<=doutb) -> ACC (alu_a=acc, alu_b=opb, acc<=alu_out, i++) -> RD_A, or WR if i was N-1. WR: wea=1, addra=base_d, dina=acc, result<=acc -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Address arithmetic modulo 2^AW (base+i wraps to 0); no error flag. Index counter LW bits.
- wea high only in WR; addra/dina don't-care otherwise but held at last value.
- Overlapping source/destination regions allowed; each element reads before it writes, no forwarding beyond that.
- rst in any state: next cycle IDLE, no further writes, in-flight element discarded.

## Timing

- Reset values: busy 0, done 0, result 0, wea 0, addra 0, dina 0, addrb 0, alu_a 0, alu_b 0, alu_op 0; internal acc/opa/opb/i 0.
- Start accepted at edge t = cycle 0; busy high from cycle 1.
- Element-wise: element k written in cycle 4k+4; DONE in cycle 4N+1; busy low in 4N+2. 4 cycles/element.
- Reduction: element k accumulated in cycle 3k+3; WR in cycle 3N+1; DONE in 3N+2; busy low in 3N+3.
- len=0: DONE in cycle 1, no RAM write, result unchanged.
- New start may be accepted in the first IDLE cycle after DONE (back-to-back).

## Test plan

- Element-wise add (op=5'h1), A@0x00={1,2,3,4}, B@0x10={10,20,30,40}, D@0x20, N=4 -> RAM 0x20..0x23 = {11,22,33,44}; done in cycle 17; result=44.
- Reduction add, A@0x00={5,6,7}, init_val=100, D@0x30, N=3 -> RAM[0x30]=118, done in cycle 11, exactly one write.
- Wrap: base_a=0xFE, base_b=0x40, base_d=0xFF, N=3 (AW=8) -> reads A from 0xFE,0xFF,0x00; writes to 0xFF,0x00,0x01.
- len=0 start -> done in cycle 1, wea never high, result holds prior value.
- start asserted continuously during a run, and op/base inputs changed mid-run -> ignored; run completes with latched values.
- rst asserted in cycle 6 of a 4-element element-wise run -> only element 0 written, busy=0 and all outputs at reset values next cycle; subsequent start runs correctly.
